// File: rtl/fmr_pkg.sv
// Shared types and helpers for the five-way redundant voting controller.
package fmr_pkg;

  localparam int N_REPL     = 5;
  localparam int THRESH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VOTE   = 2'd1,
    UPDATE = 2'd2
  } state_e;

  function automatic logic [2:0] popcount5(input logic [N_REPL-1:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < N_REPL; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/fmr_masked_majority.sv
// Combinational bitwise majority over the healthy (unmasked) replicas.
// tie_o flags any bit without a strict majority, which also covers h==0.
module fmr_masked_majority
  import fmr_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [N_REPL*W-1:0] g_i,
  input  logic [N_REPL-1:0]   fail_mask_i,
  output logic [W-1:0]        vote_o,
  output logic                tie_o
);

  logic [2:0]        h_s;
  logic [2:0]        ones_s;
  logic [3:0]        dbl_s;
  logic [N_REPL-1:0] col_s;

  // Per-bit count of healthy ones compared against half the healthy population
  always_comb begin
    h_s    = popcount5(~fail_mask_i);
    vote_o = '0;
    tie_o  = 1'b0;
    col_s  = '0;
    ones_s = 3'd0;
    dbl_s  = 4'd0;
    for (int b = 0; b < W; b++) begin
      for (int i = 0; i < N_REPL; i++) begin
        col_s[i] = g_i[i*W + b] & ~fail_mask_i[i];
      end
      ones_s = popcount5(col_s);
      dbl_s  = {ones_s, 1'b0};
      if (dbl_s > {1'b0, h_s}) begin
        vote_o[b] = 1'b1;
      end else if (dbl_s == {1'b0, h_s}) begin
        tie_o = 1'b1;
      end else begin
        vote_o[b] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fmr_vote_ctrl.sv
// FMR voting sequencer: capture, masked vote, mismatch tracking and retirement.
// Optional FMR_DISAGREE_COUNT_EN adds a saturating disagreement counter output.
module fmr_vote_ctrl
  import fmr_pkg::*;
#(
  parameter int W      = 1,
  parameter int THRESH = THRESH_DEF,
  parameter int CNT_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_REPL*W-1:0] g,
  input  logic                clear_fail,
  output logic                vote_valid,
  output logic [W-1:0]        vote_out,
  output logic                vote_ok,
  output logic [N_REPL-1:0]   fail_mask,
  output logic                alarm
`ifdef FMR_DISAGREE_COUNT_EN
  ,
  output logic [15:0]         disagree_cnt
`endif
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  state_e                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic [N_REPL*W-1:0]   cap_q, cap_d;
  logic [W-1:0]          vote_out_q, vote_out_d;
  logic                  vote_ok_q, vote_ok_d;
  logic                  vote_valid_q, vote_valid_d;
  logic [N_REPL-1:0]     fail_mask_q, fail_mask_d;
  logic [CNT_W-1:0]      cnt_q [N_REPL];
  logic [CNT_W-1:0]      cnt_d [N_REPL];
  logic [CNT_W-1:0]      cnt_inc_s [N_REPL];
  logic [N_REPL-1:0]     mis_s;
  logic [W-1:0]          maj_s;
  logic                  tie_s;

  fmr_masked_majority #(.W(W)) u_maj (
    .g_i         (cap_q),
    .fail_mask_i (fail_mask_q),
    .vote_o      (maj_s),
    .tie_o       (tie_s)
  );

  // Healthy replicas whose captured value differs from the registered vote
  always_comb begin
    mis_s = '0;
    for (int i = 0; i < N_REPL; i++) begin
      mis_s[i]     = ~fail_mask_q[i] & (cap_q[i*W +: W] != vote_out_q);
      cnt_inc_s[i] = cnt_q[i] + ONE_C;
    end
  end

  // Next-state for the sequencer, vote registers and fault bookkeeping
  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    cap_d        = cap_q;
    vote_out_d   = vote_out_q;
    vote_ok_d    = vote_ok_q;
    vote_valid_d = 1'b0;
    fail_mask_d  = fail_mask_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cap_d      = g;
          state_d    = VOTE;
          in_ready_d = 1'b0;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      VOTE: begin
        vote_out_d   = maj_s;
        vote_ok_d    = ~tie_s;
        vote_valid_d = 1'b1;
        state_d      = UPDATE;
      end
      UPDATE: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
        // A vote without a clear majority gives no trustworthy reference
        if (vote_ok_q) begin
          for (int i = 0; i < N_REPL; i++) begin
            if (fail_mask_q[i]) begin
              cnt_d[i] = cnt_q[i];
            end else if (mis_s[i]) begin
              cnt_d[i] = cnt_inc_s[i];
              if (cnt_inc_s[i] == THRESH_C) begin
                fail_mask_d[i] = 1'b1;
              end else begin
                fail_mask_d[i] = fail_mask_q[i];
              end
            end else begin
              cnt_d[i] = '0;
            end
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
    if (clear_fail) begin
      fail_mask_d = '0;
      for (int i = 0; i < N_REPL; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      fail_mask_d = fail_mask_d;
    end
  end

  // Sequencer, capture, vote and fault-state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      cap_q        <= '0;
      vote_out_q   <= '0;
      vote_ok_q    <= 1'b0;
      vote_valid_q <= 1'b0;
      fail_mask_q  <= '0;
      cnt_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      cap_q        <= cap_d;
      vote_out_q   <= vote_out_d;
      vote_ok_q    <= vote_ok_d;
      vote_valid_q <= vote_valid_d;
      fail_mask_q  <= fail_mask_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef FMR_DISAGREE_COUNT_EN
  logic [15:0] dis_q, dis_d;

  // Saturating count of published votes that were not unanimous among healthy replicas
  always_comb begin
    dis_d = dis_q;
    if (clear_fail) begin
      dis_d = 16'd0;
    end else if ((state_q == UPDATE) && (!vote_ok_q || (|mis_s))) begin
      if (dis_q != 16'hFFFF) begin
        dis_d = dis_q + 16'd1;
      end else begin
        dis_d = dis_q;
      end
    end else begin
      dis_d = dis_q;
    end
  end

  // Disagreement counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dis_q <= 16'd0;
    end else begin
      dis_q <= dis_d;
    end
  end

  assign disagree_cnt = dis_q;
`endif

  assign in_ready   = in_ready_q;
  assign vote_valid = vote_valid_q;
  assign vote_out   = vote_out_q;
  assign vote_ok    = vote_ok_q;
  assign fail_mask  = fail_mask_q;
  assign alarm      = (popcount5(~fail_mask_q) < 3'd3);

endmodule

// File: tb/tb_fmr_vote_ctrl.sv
// Directed self-checking bench for fmr_vote_ctrl (W=1, THRESH=4).
module tb_fmr_vote_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] g;
  logic       clear_fail;
  logic       vote_valid;
  logic [0:0] vote_out;
  logic       vote_ok;
  logic [4:0] fail_mask;
  logic       alarm;
`ifdef FMR_DISAGREE_COUNT_EN
  logic [15:0] disagree_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic       obs_lat_ok;
  logic [0:0] obs_vote;
  logic       obs_ok;

  always #5 clk = ~clk;

  fmr_vote_ctrl #(.W(1), .THRESH(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .g          (g),
    .clear_fail (clear_fail),
    .vote_valid (vote_valid),
    .vote_out   (vote_out),
    .vote_ok    (vote_ok),
    .fail_mask  (fail_mask),
    .alarm      (alarm)
`ifdef FMR_DISAGREE_COUNT_EN
    ,
    .disagree_cnt (disagree_cnt)
`endif
  );

  // Drives one sample and records the observed handshake timing and vote.
  task automatic run_sample(input logic [4:0] gv, input bit clr_upd);
    int  n;
    logic v1, v2, v3, r1, r2, r3;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    g        = gv;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    v1 = vote_valid; r1 = in_ready;
    @(negedge clk);
    v2 = vote_valid; r2 = in_ready;
    obs_vote = vote_out; obs_ok = vote_ok;
    if (clr_upd) clear_fail = 1'b1;
    @(negedge clk);
    v3 = vote_valid; r3 = in_ready;
    clear_fail = 1'b0;
    obs_lat_ok = (n < 20) && (v1 === 1'b0) && (v2 === 1'b1) && (v3 === 1'b0) &&
                 (r1 === 1'b0) && (r2 === 1'b0) && (r3 === 1'b1);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_fail = 1'b1;
    @(negedge clk);
    clear_fail = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1; in_valid = 1'b0; g = 5'b00000; clear_fail = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if (fail_mask !== 5'b00000) begin failures++; $display("FAIL reset_mask got=%b exp=00000", fail_mask); end
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
    checks++; if ({vote_out, vote_ok} !== 2'b00) begin failures++; $display("FAIL reset_vote got=%b%b exp=00", vote_out, vote_ok); end
`ifdef FMR_DISAGREE_COUNT_EN
    checks++; if (disagree_cnt !== 16'd0) begin failures++; $display("FAIL reset_dis got=%0d exp=0", disagree_cnt); end
`endif
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (vote_valid !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL reset_no_vv got=%0d exp=0", seen); end
  endtask

  task automatic test_single();
    run_sample(5'b00100, 1'b0);
    checks++; if (obs_lat_ok !== 1'b1) begin failures++; $display("FAIL single_latency got=%b exp=1", obs_lat_ok); end
    checks++; if ({obs_vote, obs_ok} !== 2'b01) begin failures++; $display("FAIL single_vote got=%b%b exp=01", obs_vote, obs_ok); end
    checks++; if (fail_mask !== 5'b00000) begin failures++; $display("FAIL single_mask got=%b exp=00000", fail_mask); end
`ifdef FMR_DISAGREE_COUNT_EN
    checks++; if (disagree_cnt !== 16'd1) begin failures++; $display("FAIL single_dis got=%0d exp=1", disagree_cnt); end
`endif
  endtask

  task automatic test_retire();
    run_sample(5'b00100, 1'b0);
    run_sample(5'b00100, 1'b0);
    checks++; if (fail_mask !== 5'b00000) begin failures++; $display("FAIL retire_early got=%b exp=00000", fail_mask); end
    run_sample(5'b00100, 1'b0);
    checks++; if (fail_mask !== 5'b00100) begin failures++; $display("FAIL retire_mask got=%b exp=00100", fail_mask); end
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL retire_alarm got=%b exp=0", alarm); end
  endtask

  task automatic test_tie();
    repeat (3) run_sample(5'b00001, 1'b0);
    checks++; if (fail_mask !== 5'b00100) begin failures++; $display("FAIL tie_pre_mask got=%b exp=00100", fail_mask); end
    run_sample(5'b00111, 1'b0);
    checks++; if ({obs_vote, obs_ok} !== 2'b00) begin failures++; $display("FAIL tie_vote got=%b%b exp=00", obs_vote, obs_ok); end
    checks++; if (fail_mask !== 5'b00100) begin failures++; $display("FAIL tie_frozen got=%b exp=00100", fail_mask); end
    run_sample(5'b00001, 1'b0);
    checks++; if (fail_mask !== 5'b00101) begin failures++; $display("FAIL tie_after got=%b exp=00101", fail_mask); end
    pulse_clear();
    checks++; if (fail_mask !== 5'b00000) begin failures++; $display("FAIL tie_clear got=%b exp=00000", fail_mask); end
  endtask

  task automatic test_vote_one();
    run_sample(5'b11011, 1'b0);
    checks++; if ({obs_vote, obs_ok} !== 2'b11) begin failures++; $display("FAIL one_vote got=%b%b exp=11", obs_vote, obs_ok); end
    run_sample(5'b00111, 1'b0);
    checks++; if ({obs_vote, obs_ok} !== 2'b11) begin failures++; $display("FAIL three_of_five got=%b%b exp=11", obs_vote, obs_ok); end
    pulse_clear();
  endtask

  task automatic test_alarm();
    repeat (4) run_sample(5'b00100, 1'b0);
    repeat (4) run_sample(5'b01000, 1'b0);
    checks++; if ({fail_mask, alarm} !== 6'b01100_0) begin failures++; $display("FAIL alarm_two got=%b/%b exp=01100/0", fail_mask, alarm); end
    repeat (4) run_sample(5'b10000, 1'b0);
    checks++; if ({fail_mask, alarm} !== 6'b11100_1) begin failures++; $display("FAIL alarm_three got=%b/%b exp=11100/1", fail_mask, alarm); end
    run_sample(5'b00001, 1'b0);
    checks++; if ({obs_vote, obs_ok} !== 2'b00) begin failures++; $display("FAIL alarm_tie2 got=%b%b exp=00", obs_vote, obs_ok); end
    run_sample(5'b11111, 1'b0);
    checks++; if ({obs_vote, obs_ok} !== 2'b11) begin failures++; $display("FAIL alarm_agree got=%b%b exp=11", obs_vote, obs_ok); end
    pulse_clear();
    checks++; if ({fail_mask, alarm} !== 6'b00000_0) begin failures++; $display("FAIL alarm_clear got=%b/%b exp=00000/0", fail_mask, alarm); end
  endtask

  task automatic test_clear_in_update();
    repeat (3) run_sample(5'b00010, 1'b0);
    run_sample(5'b00010, 1'b1);
    checks++; if (fail_mask !== 5'b00000) begin failures++; $display("FAIL clr_upd_mask got=%b exp=00000", fail_mask); end
    repeat (3) run_sample(5'b00010, 1'b0);
    checks++; if (fail_mask !== 5'b00000) begin failures++; $display("FAIL clr_upd_cnt got=%b exp=00000", fail_mask); end
    run_sample(5'b00010, 1'b0);
    checks++; if (fail_mask !== 5'b00010) begin failures++; $display("FAIL clr_upd_retire got=%b exp=00010", fail_mask); end
    pulse_clear();
  endtask

  task automatic test_back_to_back();
    logic [9:0] vv_pat, rdy_pat;
    vv_pat = 10'd0; rdy_pat = 10'd0;
    @(negedge clk);
    in_valid = 1'b1; g = 5'b11111;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      vv_pat[k]  = vote_valid;
      rdy_pat[k] = in_ready;
      if (k == 9) in_valid = 1'b0;
    end
    checks++; if (vv_pat !== 10'h124) begin failures++; $display("FAIL b2b_vv got=%b exp=%b", vv_pat, 10'h124); end
    checks++; if (rdy_pat !== 10'h248) begin failures++; $display("FAIL b2b_ready got=%b exp=%b", rdy_pat, 10'h248); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    repeat (4) run_sample(5'b00100, 1'b0);
    run_sample(5'b11011, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; g = 5'b11111;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (vote_valid !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_vv got=%0d exp=0", seen); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
    checks++; if ({vote_out, vote_ok, fail_mask, alarm} !== 8'b0) begin failures++; $display("FAIL midrst_outs got=%b%b/%b/%b exp=00/00000/0", vote_out, vote_ok, fail_mask, alarm); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_retire();
    test_tie();
    test_vote_one();
    test_alarm();
    test_clear_in_update();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fmr_vote_ctrl.md
Name: fmr_vote_ctrl

Overview:
- Sequencing and fault-management controller for the five-way redundant (FMR) voting datapath.
- Accepts one sample of five replica outputs (g1..g5) per handshake and produces a masked majority vote.
- Tracks consecutive disagreements per replica and retires a replica from voting once it reaches a threshold.
- Raises an alarm when too few healthy replicas remain to out-vote a fault.

Parameters:
- W, 1: data width of each replica output.
- THRESH, 4: consecutive mismatches that mark a replica failed (range 1..7).
- CNT_W, 3: mismatch counter width; must satisfy 2**CNT_W > THRESH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-high.
- in_valid  in  1  sample on g is valid.
- in_ready  out  1  controller can accept a sample.
- g  in  5*W  replica outputs; g[i*W +: W] is replica i+1 (g1..g5).
- clear_fail  in  1  single-cycle pulse: restore all replicas to healthy.
- vote_valid  out  1  one-cycle pulse; vote_out and vote_ok are valid.
- vote_out  out  W  masked majority result.
- vote_ok  out  1  every bit had a strict majority among healthy replicas.
- fail_mask  out  5  bit i set means replica i+1 is retired.
- alarm  out  1  fewer than 3 healthy replicas.

Behaviour:
- Reset values:
  - in_ready=1 (state IDLE).
  - vote_valid=0, vote_out=0, vote_ok=0, fail_mask=0, alarm=0.
  - All mismatch counters 0; capture register 0.
- FSM states: IDLE -> VOTE -> UPDATE -> IDLE.
  - IDLE: in_ready=1. When in_valid=1, capture g, go to VOTE. Otherwise hold.
  - VOTE: in_ready=0. Compute the vote from the capture register and fail_mask; register vote_out and vote_ok.
  - UPDATE: in_ready=0. vote_valid=1 for this cycle only; update counters and fail_mask; return to IDLE.
- Latency and throughput:
  - Handshake accepted at cycle 0; vote_valid is high in cycle 2.
  - Next accept possible in cycle 3, giving 1 sample per 3 cycles.
- Vote arithmetic:
  - h = number of healthy replicas (0..5).
  - Per bit, ones = count of healthy replicas with that bit set.
  - Bit result is 1 if 2*ones > h, 0 otherwise.
  - vote_ok=0 if any bit has 2*ones == h (tie), or if h==0.
- Counter update (UPDATE state, healthy replicas only):
  - Replica differs from vote_out in any bit: counter += 1.
  - Replica matches: counter is cleared to 0.
  - Counter reaching THRESH sets its fail_mask bit.
  - Counters of retired replicas are frozen.
  - No counter updates occur when vote_ok=0.
- alarm is combinational from the registered fail_mask: alarm = (popcount(~fail_mask) < 3).
- clear_fail:
  - Clears fail_mask and all counters in any state.
  - Takes priority over a fail_mask set in the same UPDATE cycle.
  - The vote already in flight is unaffected.
- Reset mid-operation: FSM returns to IDLE immediately and the captured sample is discarded. No vote_valid pulse follows.
- in_valid held high in VOTE/UPDATE is ignored. The sample is taken only when in_ready=1.

Optional Feature:
- Macro FMR_DISAGREE_COUNT_EN.
- Defined: adds output port disagree_cnt [15:0].
  - Saturating count of vote_valid cycles in which any healthy replica disagreed with vote_out, or vote_ok=0.
  - Reset to 0; cleared by clear_fail.
- Undefined: port absent, no counter logic.

Decomposition:
- Package fmr_pkg holds:
  - N_REPL=5.
  - State enum {IDLE, VOTE, UPDATE}.
  - Default THRESH.
  - Popcount function.
- Sub-module fmr_masked_majority: purely combinational.
  - Inputs: replica vector and fail_mask.
  - Outputs: vote bits and tie flag.
  - Instantiated once in VOTE.

Test Plan (W=1, THRESH=4):
- Reset, no stimulus -> in_ready=1, fail_mask=00000, alarm=0, vote_valid never pulses.
- Accept g=5'b00100 -> vote_valid in cycle 2 with vote_out=0, vote_ok=1; replica 3 counter=1, fail_mask=00000.
- Four consecutive samples g=5'b00100 -> fail_mask=5'b00100 after the 4th vote_valid. Next sample g=5'b00111: healthy {1,2,4,5}, ones=2 of 4 -> vote_out=0, vote_ok=0, counters unchanged.
- Retire replicas 3, 4, 5 in turn (4 mismatches each) -> alarm=1 once fail_mask=5'b11100. clear_fail pulse -> fail_mask=00000, alarm=0 next cycle.
- clear_fail asserted in the UPDATE cycle of the 4th mismatch of replica 2 -> fail_mask stays 00000 and the replica 2 counter is 0.
- rst asserted during VOTE for g=5'b11111 -> no vote_valid; in_ready=1 after release, all outputs at reset values.
